// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer feeding a four-state stability-check
// FSM. Produces a clean debounced level plus single-cycle press/release
// strobes for the alarm-clock control FSM.
//
// Optional feature macro: DEBOUNCER_LONG_PRESS_EN
//   defined   -> hold counter and long_press strobe are built
//   undefined -> no hold counter; long_press is tied to 0
module button_debouncer #(
    parameter int   STABLE_CYCLES = 32,   // agreeing samples to accept a change (>=2)
    parameter int   CNT_W         = 6,    // 2**CNT_W > STABLE_CYCLES
    parameter logic ACTIVE_LEVEL  = 1'b1, // raw level meaning "pressed"
    parameter int   LONG_CYCLES   = 1000, // held cycles before long_press (>=2)
    parameter int   LONG_W        = 10    // 2**LONG_W >= LONG_CYCLES
) (
    input  logic clk_fast,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    typedef enum logic [1:0] {
        RELEASED      = 2'b00,
        CHECK_PRESS   = 2'b01,
        PRESSED       = 2'b10,
        CHECK_RELEASE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, release_nxt;

    logic s1, s2;
    logic act;

    // Two-flop synchronizer; reset parks both stages at the released level
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            s1 <= ~ACTIVE_LEVEL;
            s2 <= ~ACTIVE_LEVEL;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Polarity-normalized "pressed" sample; the FSM only ever sees this
    assign act = (s2 == ACTIVE_LEVEL);

    // FSM state, stability counter and registered outputs
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state         <= RELEASED;
            cnt           <= CNT_ZERO;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Next-state / next-output logic. A check state counts agreeing samples;
    // the first sample arrives with the transition into the check state, so
    // the counter enters at 1 and accepts when the STABLE_CYCLES-th agreeing
    // sample is seen (cnt == STABLE_CYCLES-1). Any disagreeing sample drops
    // back to the stable state with the counter cleared.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                level_nxt = 1'b0;
                if (act) begin
                    state_nxt = CHECK_PRESS;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = CNT_ZERO;
                end
            end
            CHECK_PRESS: begin
                level_nxt = 1'b0;
                if (!act) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_ZERO;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                level_nxt = 1'b1;
                if (!act) begin
                    state_nxt = CHECK_RELEASE;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = CNT_ZERO;
                end
            end
            CHECK_RELEASE: begin
                level_nxt = 1'b1;
                if (act) begin
                    // bounce back: level never dropped, so no strobe
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = CNT_ZERO;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt     = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = CNT_ZERO;
                level_nxt = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCER_LONG_PRESS_EN
    // Saturation point for the hold counter. When LONG_CYCLES equals
    // 2**LONG_W it is not representable, so saturate at all-ones instead;
    // the strobe only depends on passing through LONG_CYCLES-1 once.
    localparam int HOLD_MAX_I = (1 << LONG_W) - 1;
    localparam int HOLD_SAT_I = (LONG_CYCLES > HOLD_MAX_I) ? HOLD_MAX_I : LONG_CYCLES;
    localparam logic [LONG_W-1:0] HOLD_SAT  = LONG_W'(HOLD_SAT_I);
    localparam logic [LONG_W-1:0] HOLD_FIRE = LONG_W'(LONG_CYCLES - 2);

    logic [LONG_W-1:0] hold_cnt, hold_nxt;
    logic              long_nxt;

    // Hold counter: cleared on an accepted press and whenever heading into
    // RELEASED, counts while the debounced level is high (a release bounce
    // does not clear it). The strobe fires on the step to LONG_CYCLES-1.
    always_comb begin
        hold_nxt = hold_cnt;
        long_nxt = 1'b0;
        if ((state == CHECK_PRESS && state_nxt == PRESSED) || state_nxt == RELEASED) begin
            hold_nxt = '0;
        end else if (state == PRESSED || state == CHECK_RELEASE) begin
            if (hold_cnt != HOLD_SAT) begin
                hold_nxt = hold_cnt + LONG_W'(1);
            end
            long_nxt = (hold_cnt == HOLD_FIRE);
        end
    end

    // Hold counter and registered long_press strobe
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            hold_cnt   <= hold_nxt;
            long_press <= long_nxt;
        end
    end
`else
    // Feature disabled: no hold counter, strobe permanently low
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer: hand-written timing sequences plus a
// table of stimulus segments whose expected strobe counts and final level
// go through a scoreboard queue.
`timescale 1ns/1ps
module tb_button_debouncer;

    logic clk_fast = 1'b0;
    logic rst      = 1'b1;
    logic btn_raw  = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_press;

    always #5 clk_fast = ~clk_fast;

    button_debouncer dut (
        .clk_fast      (clk_fast),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    typedef struct {
        logic rst;
        logic btn;
        int   cycles;
        int   exp_press;
        int   exp_rel;
        logic exp_level;
    } vec_t;

    typedef struct {
        int   press;
        int   rel;
        logic level;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int press_cnt = 0, rel_cnt = 0, long_cnt = 0, overlap_cnt = 0;
    int press_cyc = 0, long_cyc = 0;

    // Strobe monitor: samples 1 ns after each edge (main thread acts at 2 ns)
    always begin
        @(posedge clk_fast);
        #1;
        cyc++;
        if (press_pulse === 1'b1) begin press_cnt++; press_cyc = cyc; end
        if (release_pulse === 1'b1) rel_cnt++;
        if (long_press === 1'b1) begin long_cnt++; long_cyc = cyc; end
        if ((int'(press_pulse) + int'(release_pulse) + int'(long_press)) > 1) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_fast);
            #2;
        end
    endtask

    initial begin
        int p0, r0, l0, bad;
        exp_t e;

        // segment table; starts from RELEASED with btn_raw low
        for (int k = 0; k < 10; k++) begin
            tbl.push_back('{1'b0, 1'b1, 31, 0, 0, 1'b0}); // 31 samples: one short
            tbl.push_back('{1'b0, 1'b0, 3,  0, 0, 1'b0});
        end
        tbl.push_back('{1'b0, 1'b1, 40, 1, 0, 1'b1}); // clean press
        tbl.push_back('{1'b0, 1'b0, 31, 0, 0, 1'b1}); // release glitch rejected
        tbl.push_back('{1'b0, 1'b1, 40, 0, 0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 40, 0, 1, 1'b0}); // clean release
        tbl.push_back('{1'b0, 1'b1, 40, 1, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2,  0, 0, 1'b0}); // reset while pressed
        tbl.push_back('{1'b0, 1'b1, 40, 1, 0, 1'b1}); // full re-check after reset
        tbl.push_back('{1'b0, 1'b0, 40, 0, 1, 1'b0});

        // reset and idle
        rst = 1'b1; btn_raw = 1'b0;
        step(3);
        rst = 1'b0;
        check("reset_level", btn_level, 0);
        check("reset_press", press_pulse, 0);
        check("reset_release", release_pulse, 0);
        check("reset_long", long_press, 0);
        bad = 0;
        repeat (100) begin
            step(1);
            if ((btn_level | press_pulse | release_pulse | long_press) !== 1'b0) bad++;
        end
        check("idle_100_outputs", bad, 0);

        // press latency: change before edge N, strobe after edge N+33
        p0 = press_cnt;
        btn_raw = 1'b1;
        step(33);
        check("press_not_early", press_cnt - p0, 0);
        check("level_not_early", btn_level, 0);
        step(1);
        check("press_pulse_edge", press_pulse, 1);
        check("press_level_edge", btn_level, 1);
        step(1);
        check("press_pulse_one_cycle", press_pulse, 0);
        check("press_level_hold", btn_level, 1);
        check("press_count", press_cnt - p0, 1);

        // pressed: low 20, high 5, low 40 -> one release 33 edges after last fall
        p0 = press_cnt; r0 = rel_cnt;
        btn_raw = 1'b0; step(20);
        btn_raw = 1'b1; step(5);
        btn_raw = 1'b0; step(33);
        check("bounce_release_not_early", rel_cnt - r0, 0);
        check("bounce_level_held", btn_level, 1);
        step(1);
        check("bounce_release_edge", release_pulse, 1);
        check("bounce_release_level", btn_level, 0);
        step(6);
        check("bounce_release_count", rel_cnt - r0, 1);
        check("bounce_no_press", press_cnt - p0, 0);

        // table-driven segments through the scoreboard
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            btn_raw = tbl[i].btn;
            p0 = press_cnt; r0 = rel_cnt;
            sb.push_back('{tbl[i].exp_press, tbl[i].exp_rel, tbl[i].exp_level});
            step(tbl[i].cycles);
            e = sb.pop_front();
            check($sformatf("vec%0d_press", i), press_cnt - p0, e.press);
            check($sformatf("vec%0d_release", i), rel_cnt - r0, e.rel);
            check($sformatf("vec%0d_level", i), btn_level, e.level);
        end
        rst = 1'b0;

        // reset 20 cycles into CHECK_PRESS: the full check restarts
        btn_raw = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0;
        p0 = press_cnt;
        btn_raw = 1'b1;
        step(22);
        check("midcheck_no_press", press_cnt - p0, 0);
        rst = 1'b1; step(1); rst = 1'b0;
        step(33);
        check("restart_not_early", press_cnt - p0, 0);
        check("restart_level_low", btn_level, 0);
        step(1);
        check("restart_press_edge", press_pulse, 1);
        step(5);
        check("restart_press_once", press_cnt - p0, 1);

        // long hold
        btn_raw = 1'b0; step(40);
        p0 = press_cnt; r0 = rel_cnt; l0 = long_cnt;
        btn_raw = 1'b1;
        step(1200);
        check("long_hold_press", press_cnt - p0, 1);
`ifdef DEBOUNCER_LONG_PRESS_EN
        check("long_press_once", long_cnt - l0, 1);
        check("long_press_delay", long_cyc - press_cyc, 999);
`else
        check("long_press_absent", long_cnt - l0, 0);
`endif
        btn_raw = 1'b0; step(40);
        check("long_release", rel_cnt - r0, 1);
        check("long_no_extra", long_cnt - l0, (long_cnt - l0 > 0) ? 1 : 0);
        check("strobe_overlap", overlap_cnt, 0);
        check("final_level", btn_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
